// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and data access.
// Optional build macro ARB_PERF_CNT_EN adds per-requester stall-cycle counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
`endif
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STV_W-1:0]   starve_cnt;
  logic               op_we;
  logic               done_c;
  logic               free_c;
  logic               starved_c;
  logic               grant_if_c;
  logic               grant_dm_c;

  // Response cycle doubles as an arbitration cycle, so accesses run back to back.
  assign done_c    = (state != IDLE) && (lat_cnt == '0);
  assign free_c    = (state == IDLE) || done_c;
  assign starved_c = (starve_cnt == STV_W'(STARVE_MAX));

  assign if_rvalid = (state == BUSY_IF) && (lat_cnt == '0);
  assign dm_rvalid = (state == BUSY_DM) && (lat_cnt == '0);
  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = dm_req & ~dm_rvalid;

  // Data port wins ties unless fetch has lost STARVE_MAX times in a row.
  always_comb begin
    grant_if_c = 1'b0;
    grant_dm_c = 1'b0;
    if (free_c) begin
      if (if_req && dm_req) begin
        if (starved_c) grant_if_c = 1'b1;
        else           grant_dm_c = 1'b1;
      end else if (if_req) begin
        grant_if_c = 1'b1;
      end else if (dm_req) begin
        grant_dm_c = 1'b1;
      end
    end
  end

  assign if_gnt    = grant_if_c;
  assign dm_gnt    = grant_dm_c;
  assign mem_en    = grant_if_c | grant_dm_c;
  assign mem_we    = grant_dm_c & dm_we;
  assign mem_addr  = grant_dm_c ? dm_addr  : (grant_if_c ? if_addr : '0);
  assign mem_wdata = grant_dm_c ? dm_wdata : '0;

  // Access tracking, response capture and starvation bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      op_we      <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if (if_rvalid) if_rdata <= mem_rdata;
      if (dm_rvalid && !op_we) dm_rdata <= mem_rdata;

      if (grant_if_c) begin
        state      <= BUSY_IF;
        lat_cnt    <= LAT_W'(MEM_LAT - 1);
        op_we      <= 1'b0;
        starve_cnt <= '0;
      end else if (grant_dm_c) begin
        state   <= BUSY_DM;
        lat_cnt <= LAT_W'(MEM_LAT - 1);
        op_we   <= dm_we;
        if (if_req && !starved_c) starve_cnt <= starve_cnt + STV_W'(1);
      end else if (done_c) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Free-running stall-cycle counters; wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_stall <= '0;
      perf_dm_stall <= '0;
    end else begin
      if (stall_if)  perf_if_stall <= perf_if_stall + 32'd1;
      if (stall_mem) perf_dm_stall <= perf_dm_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=2, STARVE_MAX=4.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall;
  logic [31:0] perf_dm_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    step(); step();
    @(negedge clk);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
    step(); rst = 1'b0;

    // Lone fetch, then a back-to-back fetch issued in the response cycle
    step(); if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("f_gnt", 64'(if_gnt), 64'd1);
    chk("f_mem_en", 64'(mem_en), 64'd1);
    chk("f_mem_we", 64'(mem_we), 64'd0);
    chk("f_addr", 64'(mem_addr), 64'h10);
    chk("f_dm_gnt", 64'(dm_gnt), 64'd0);
    chk("f_stall_t0", 64'(stall_if), 64'd1);
    step(); if_addr = 32'h10;
    @(negedge clk);
    chk("f_busy_en", 64'(mem_en), 64'd0);
    chk("f_busy_addr", 64'(mem_addr), 64'd0);
    chk("f_stall_t1", 64'(stall_if), 64'd1);
    chk("f_rvalid_t1", 64'(if_rvalid), 64'd0);
    step(); if_addr = 32'h14;
    @(negedge clk);
    chk("f_rvalid_t2", 64'(if_rvalid), 64'd1);
    chk("f_stall_t2", 64'(stall_if), 64'd0);
    chk("f_b2b_gnt", 64'(if_gnt), 64'd1);
    chk("f_b2b_addr", 64'(mem_addr), 64'h14);
    step(); mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("f_rdata", 64'(if_rdata), 64'hDEADBEEF);
    chk("f_rvalid_t3", 64'(if_rvalid), 64'd0);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("f2_rvalid", 64'(if_rvalid), 64'd1);
    chk("f2_no_gnt", 64'(if_gnt), 64'd0);
    step();
    @(negedge clk);
    chk("f2_rdata", 64'(if_rdata), 64'h12345678);

    // Simultaneous requests: data first, fetch issues in the data response cycle
    step(); if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; mem_rdata = 32'h0;
    @(negedge clk);
    chk("b_dm_gnt", 64'(dm_gnt), 64'd1);
    chk("b_if_gnt", 64'(if_gnt), 64'd0);
    chk("b_addr", 64'(mem_addr), 64'h100);
    chk("b_stall_mem", 64'(stall_mem), 64'd1);
    step();
    step(); dm_req = 1'b0; mem_rdata = 32'hA5A50001;
    @(negedge clk);
    chk("b_dm_rvalid", 64'(dm_rvalid), 64'd1);
    chk("b_if_gnt_t2", 64'(if_gnt), 64'd1);
    chk("b_addr_t2", 64'(mem_addr), 64'h40);
    chk("b_stall_mem_t2", 64'(stall_mem), 64'd0);
    step(); mem_rdata = 32'hC0DE0003;
    @(negedge clk);
    chk("b_dm_rdata", 64'(dm_rdata), 64'hA5A50001);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("b_if_rvalid_t4", 64'(if_rvalid), 64'd1);
    step();
    @(negedge clk);
    chk("b_if_rdata", 64'(if_rdata), 64'hC0DE0003);

    // Store: write strobes at issue, data-side read data untouched
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
    @(negedge clk);
    chk("s_gnt", 64'(dm_gnt), 64'd1);
    chk("s_mem_we", 64'(mem_we), 64'd1);
    chk("s_addr", 64'(mem_addr), 64'h20);
    chk("s_wdata", 64'(mem_wdata), 64'h55);
    step();
    @(negedge clk);
    chk("s_busy_we", 64'(mem_we), 64'd0);
    chk("s_busy_wdata", 64'(mem_wdata), 64'd0);
    step(); dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("s_rvalid", 64'(dm_rvalid), 64'd1);
    step();
    @(negedge clk);
    chk("s_rdata_kept", 64'(dm_rdata), 64'hA5A50001);

    // Starvation: data keeps requesting, fetch forced through on the fifth grant
    step(); if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("st_dm_gnt%0d", k), 64'(dm_gnt), 64'd1);
      chk($sformatf("st_if_lose%0d", k), 64'(if_gnt), 64'd0);
      step(); step();
    end
    @(negedge clk);
    chk("st_dm_rvalid4", 64'(dm_rvalid), 64'd1);
    chk("st_if_forced", 64'(if_gnt), 64'd1);
    chk("st_dm_lose", 64'(dm_gnt), 64'd0);
    step();
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("st_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("st_dm_alone", 64'(dm_gnt), 64'd1);
    step();
    step(); if_req = 1'b1;
    @(negedge clk);
    chk("st_cleared_dm", 64'(dm_gnt), 64'd1);
    chk("st_cleared_if", 64'(if_gnt), 64'd0);
    step();
    step(); dm_req = 1'b0;
    @(negedge clk);
    chk("st_tail_if_gnt", 64'(if_gnt), 64'd1);
    step();
    step(); if_req = 1'b0;
    step();

    // Reset during a data load abandons it without a response
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("r_dm_gnt", 64'(dm_gnt), 64'd1);
    step(); rst = 1'b1; dm_req = 1'b0;
    #1;
    chk("r_async_rvalid", 64'(dm_rvalid), 64'd0);
    chk("r_async_en", 64'(mem_en), 64'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("r_no_rvalid", 64'(dm_rvalid), 64'd0);
    chk("r_dm_rdata", 64'(dm_rdata), 64'd0);
    chk("r_if_rdata", 64'(if_rdata), 64'd0);
    step();
    @(negedge clk);
    chk("r_no_rvalid_late", 64'(dm_rvalid), 64'd0);

`ifdef ARB_PERF_CNT_EN
    step(); if_req = 1'b1; if_addr = 32'h10;
    step();
    step(); if_req = 1'b0;
    step();
    @(negedge clk);
    chk("p_if_stall", 64'(perf_if_stall), 64'd2);
    chk("p_dm_stall", 64'(perf_dm_stall), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
